booth_mult_ctrl: RTL



---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_addsub.sv | 13 +
 rtl/booth_mult_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and encodings for the radix-2 Booth multiplier datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_ADD = 1'b1;
  localparam logic SEL_SUB = 1'b0;

  // {Q[0], q_1} pairs that require an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/sub unit: sel=1 adds, sel=0 subtracts.
module booth_addsub #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? (in0 + in1) : (in0 - in1);

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed
// WIDTH x WIDTH operands, registered 2*WIDTH product with a done pulse.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = WIDTH + 1;

  state_t           state, state_nxt;
  logic [AW-1:0]    a_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       pair_c;
  logic             sel_c;
  logic             last_c;
  logic [AW-1:0]    sum_c, a_new_c, a_sh_c;
  logic [WIDTH-1:0] q_sh_c;
  logic             busy_nxt, done_nxt;

  booth_addsub #(.W(AW)) u_addsub (
    .in0 (a_q),
    .in1 (m_q),
    .sel (sel_c),
    .out (sum_c)
  );

  // Booth step: pick add/sub/none, then arithmetic shift {A,Q,q_1} right
  always_comb begin
    pair_c  = {q_q[0], q1_q};
    sel_c   = (pair_c == BOOTH_ADD) ? SEL_ADD : SEL_SUB;
    a_new_c = ((pair_c == BOOTH_ADD) || (pair_c == BOOTH_SUB)) ? sum_c : a_q;
    a_sh_c  = {a_new_c[AW-1], a_new_c[AW-1:1]};
    q_sh_c  = {a_new_c[0], q_q[WIDTH-1:1]};
    last_c  = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= '0;
            m_q   <= {mcand[WIDTH-1], mcand};
            q_q   <= mplier;
            q1_q  <= 1'b0;
            cnt_q <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          a_q   <= a_sh_c;
          q_q   <= q_sh_c;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_c) product <= {a_sh_c[WIDTH-1:0], q_sh_c};
        end
        default: ;
      endcase
    end
  end

endmodule
